// File: rtl/wb_scr1_arb_pkg.sv
// Shared types and constants for the SCR1 instruction/data Wishbone arbiter.
package wb_scr1_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN_I = 2'd1,
        ARB_OWN_D = 2'd2
    } arb_state_e;

    localparam logic [1:0]  GNT_NONE = 2'b00;
    localparam logic [1:0]  GNT_I    = 2'b01;
    localparam logic [1:0]  GNT_D    = 2'b10;

    localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_scr1_arb_watchdog.sv
// Stall watchdog for the arbiter: counts owner STB cycles without ACK and
// raises a one-cycle fire pulse plus a sticky timeout flag.
module wb_scr1_arb_watchdog #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_stall,
    output logic o_fire,
    output logic o_timeout
);

    logic [7:0] r_cnt;
    logic       r_flag;

    assign o_fire    = (r_cnt == LIMIT);
    assign o_timeout = r_flag;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else begin
            if (o_fire) begin
                r_flag <= 1'b1;
            end
            // The fire cycle itself counts as the ack that ends the wait.
            if (i_clr || o_fire) begin
                r_cnt <= '0;
            end else if (i_stall) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/wb_scr1_bus_arbiter.sv
// Shares one Wishbone master port between the SCR1 instruction and data masters.
// Optional stall watchdog enabled by defining WB_SCR1_ARB_TIMEOUT_EN.
module wb_scr1_bus_arbiter
    import wb_scr1_arb_pkg::*;
#(
    parameter int FIXED_PRIO  = 0,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic [31:0] wbs_instr_adr_i,
    input  logic [31:0] wbs_instr_dat_i,
    input  logic        wbs_instr_we_i,
    input  logic [3:0]  wbs_instr_sel_i,
    input  logic        wbs_instr_stb_i,
    input  logic        wbs_instr_cyc_i,
    output logic        wbs_instr_ack_o,
    output logic [31:0] wbs_instr_dat_o,

    input  logic [31:0] wbs_data_adr_i,
    input  logic [31:0] wbs_data_dat_i,
    input  logic        wbs_data_we_i,
    input  logic [3:0]  wbs_data_sel_i,
    input  logic        wbs_data_stb_i,
    input  logic        wbs_data_cyc_i,
    output logic        wbs_data_ack_o,
    output logic [31:0] wbs_data_dat_o,

    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    arb_state_e r_state;
    arb_state_e w_next_state;
    logic       r_last_d;
    logic       w_win_d;
    logic       w_fire;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state  <= ARB_IDLE;
            r_last_d <= 1'b1;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == ARB_OWN_I) begin
                r_last_d <= 1'b0;
            end else if (w_next_state == ARB_OWN_D) begin
                r_last_d <= 1'b1;
            end
        end
    end

    // A releasing owner has cyc=0, so only the other master can win the handoff.
    always_comb begin
        w_next_state = r_state;
        w_win_d      = (FIXED_PRIO != 0) || !r_last_d;
        case (r_state)
            ARB_IDLE: begin
                if (wbs_instr_cyc_i && wbs_data_cyc_i) begin
                    w_next_state = w_win_d ? ARB_OWN_D : ARB_OWN_I;
                end else if (wbs_instr_cyc_i) begin
                    w_next_state = ARB_OWN_I;
                end else if (wbs_data_cyc_i) begin
                    w_next_state = ARB_OWN_D;
                end
            end
            ARB_OWN_I: begin
                if (!wbs_instr_cyc_i) begin
                    w_next_state = wbs_data_cyc_i ? ARB_OWN_D : ARB_IDLE;
                end
            end
            ARB_OWN_D: begin
                if (!wbs_data_cyc_i) begin
                    w_next_state = wbs_instr_cyc_i ? ARB_OWN_I : ARB_IDLE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    always_comb begin
        wbm_adr_o       = '0;
        wbm_dat_o       = '0;
        wbm_we_o        = 1'b0;
        wbm_sel_o       = '0;
        wbm_stb_o       = 1'b0;
        wbm_cyc_o       = 1'b0;
        wbs_instr_ack_o = 1'b0;
        wbs_instr_dat_o = '0;
        wbs_data_ack_o  = 1'b0;
        wbs_data_dat_o  = '0;
        grant_o         = GNT_NONE;
        case (r_state)
            ARB_OWN_I: begin
                wbm_adr_o       = wbs_instr_adr_i;
                wbm_dat_o       = wbs_instr_dat_i;
                wbm_we_o        = wbs_instr_we_i;
                wbm_sel_o       = wbs_instr_sel_i;
                wbm_stb_o       = wbs_instr_stb_i && !w_fire;
                wbm_cyc_o       = wbs_instr_cyc_i && !w_fire;
                wbs_instr_ack_o = wbm_ack_i || w_fire;
                wbs_instr_dat_o = w_fire ? ARB_TIMEOUT_DATA : wbm_dat_i;
                grant_o         = GNT_I;
            end
            ARB_OWN_D: begin
                wbm_adr_o      = wbs_data_adr_i;
                wbm_dat_o      = wbs_data_dat_i;
                wbm_we_o       = wbs_data_we_i;
                wbm_sel_o      = wbs_data_sel_i;
                wbm_stb_o      = wbs_data_stb_i && !w_fire;
                wbm_cyc_o      = wbs_data_cyc_i && !w_fire;
                wbs_data_ack_o = wbm_ack_i || w_fire;
                wbs_data_dat_o = w_fire ? ARB_TIMEOUT_DATA : wbm_dat_i;
                grant_o        = GNT_D;
            end
            default: ;
        endcase
    end

`ifdef WB_SCR1_ARB_TIMEOUT_EN
    logic w_own;
    logic w_clr;
    logic w_stall;
    logic w_wd_fire;

    assign w_own   = (r_state != ARB_IDLE);
    assign w_clr   = (w_next_state != r_state) || wbm_ack_i;
    assign w_stall = w_own && wbm_stb_o && !wbm_ack_i;

    wb_scr1_arb_watchdog #(
        .LIMIT(8'(TIMEOUT_CYC))
    ) u_watchdog (
        .i_clk     (wb_clk_i),
        .i_rst     (wb_rst_i),
        .i_clr     (w_clr),
        .i_stall   (w_stall),
        .o_fire    (w_wd_fire),
        .o_timeout (timeout_o)
    );

    assign w_fire = w_own && w_wd_fire;
`else
    assign w_fire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_scr1_bus_arbiter.sv
// Bench for wb_scr1_bus_arbiter: round-robin and fixed-priority instances share
// stimulus and are checked every cycle against an owner-based reference model.
module tb_wb_scr1_bus_arbiter;

`ifdef WB_SCR1_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_adr, i_dat, d_adr, d_dat, s_dat;
    logic        i_we, i_stb, i_cyc, d_we, d_stb, d_cyc, s_ack;
    logic [3:0]  i_sel, d_sel;

    logic        ia [2];
    logic        da [2];
    logic        mwe [2];
    logic        mstb [2];
    logic        mcyc [2];
    logic        tmo [2];
    logic [31:0] idat [2];
    logic [31:0] ddat [2];
    logic [31:0] madr [2];
    logic [31:0] mdat [2];
    logic [3:0]  msel [2];
    logic [1:0]  gnt [2];

    int checks   = 0;
    int failures = 0;

    // Model: owner 0 = none, 1 = instr, 2 = data; last = last granted master.
    int m_own [2];
    int m_last [2];
    int m_cnt [2];
    bit m_tmo [2];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        wb_scr1_bus_arbiter #(
            .FIXED_PRIO  (k),
            .TIMEOUT_CYC (TMO)
        ) u_dut (
            .wb_clk_i        (clk),
            .wb_rst_i        (rst),
            .wbs_instr_adr_i (i_adr),
            .wbs_instr_dat_i (i_dat),
            .wbs_instr_we_i  (i_we),
            .wbs_instr_sel_i (i_sel),
            .wbs_instr_stb_i (i_stb),
            .wbs_instr_cyc_i (i_cyc),
            .wbs_instr_ack_o (ia[k]),
            .wbs_instr_dat_o (idat[k]),
            .wbs_data_adr_i  (d_adr),
            .wbs_data_dat_i  (d_dat),
            .wbs_data_we_i   (d_we),
            .wbs_data_sel_i  (d_sel),
            .wbs_data_stb_i  (d_stb),
            .wbs_data_cyc_i  (d_cyc),
            .wbs_data_ack_o  (da[k]),
            .wbs_data_dat_o  (ddat[k]),
            .wbm_adr_o       (madr[k]),
            .wbm_dat_o       (mdat[k]),
            .wbm_we_o        (mwe[k]),
            .wbm_sel_o       (msel[k]),
            .wbm_stb_o       (mstb[k]),
            .wbm_cyc_o       (mcyc[k]),
            .wbm_dat_i       (s_dat),
            .wbm_ack_i       (s_ack),
            .grant_o         (gnt[k]),
            .timeout_o       (tmo[k])
        );
    end

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%h required=%h t=%0t", name, k, act, exp, $time);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            bit          fire;
            logic [31:0] e_adr, e_dat, e_idat, e_ddat;
            logic [3:0]  e_sel;
            logic        e_we, e_stb, e_cyc, e_ia, e_da;
            fire   = TMO_EN && (m_own[k] != 0) && (m_cnt[k] == TMO);
            e_adr  = '0; e_dat = '0; e_sel = '0; e_we = 1'b0;
            e_stb  = 1'b0; e_cyc = 1'b0;
            e_ia   = 1'b0; e_da = 1'b0; e_idat = '0; e_ddat = '0;
            if (m_own[k] == 1) begin
                e_adr = i_adr; e_dat = i_dat; e_sel = i_sel; e_we = i_we;
                e_stb = i_stb && !fire; e_cyc = i_cyc && !fire;
                e_ia  = s_ack || fire;
                e_idat = fire ? 32'hDEAD_BEEF : s_dat;
            end else if (m_own[k] == 2) begin
                e_adr = d_adr; e_dat = d_dat; e_sel = d_sel; e_we = d_we;
                e_stb = d_stb && !fire; e_cyc = d_cyc && !fire;
                e_da  = s_ack || fire;
                e_ddat = fire ? 32'hDEAD_BEEF : s_dat;
            end
            chk("grant",     k, 32'(gnt[k]),  32'(m_own[k]));
            chk("wbm_adr",   k, madr[k],      e_adr);
            chk("wbm_dat",   k, mdat[k],      e_dat);
            chk("wbm_sel",   k, 32'(msel[k]), 32'(e_sel));
            chk("wbm_we",    k, 32'(mwe[k]),  32'(e_we));
            chk("wbm_stb",   k, 32'(mstb[k]), 32'(e_stb));
            chk("wbm_cyc",   k, 32'(mcyc[k]), 32'(e_cyc));
            chk("instr_ack", k, 32'(ia[k]),   32'(e_ia));
            chk("instr_dat", k, idat[k],      e_idat);
            chk("data_ack",  k, 32'(da[k]),   32'(e_da));
            chk("data_dat",  k, ddat[k],      e_ddat);
            chk("timeout",   k, 32'(tmo[k]),  32'(m_tmo[k]));
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_own[k] = 0; m_last[k] = 2; m_cnt[k] = 0; m_tmo[k] = 1'b0;
            end else begin
                bit own_cyc, own_stb, fire;
                int nxt;
                own_cyc = (m_own[k] == 1) ? i_cyc : (m_own[k] == 2) ? d_cyc : 1'b0;
                own_stb = (m_own[k] == 1) ? i_stb : (m_own[k] == 2) ? d_stb : 1'b0;
                fire    = TMO_EN && (m_own[k] != 0) && (m_cnt[k] == TMO);
                nxt     = m_own[k];
                if (m_own[k] == 0 || !own_cyc) begin
                    if (i_cyc && d_cyc) nxt = (k == 1) ? 2 : ((m_last[k] == 2) ? 1 : 2);
                    else if (i_cyc)     nxt = 1;
                    else if (d_cyc)     nxt = 2;
                    else                nxt = 0;
                end
                if (fire) m_tmo[k] = 1'b1;
                if (nxt != m_own[k] || s_ack || fire) m_cnt[k] = 0;
                else if (m_own[k] != 0 && own_stb) m_cnt[k]++;
                if (nxt != 0) m_last[k] = nxt;
                m_own[k] = nxt;
            end
        end
    endtask

    task automatic settle();
        #2;
        check_model();
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_adr = '0; i_dat = '0; i_we = 1'b0; i_sel = '0; i_stb = 1'b0; i_cyc = 1'b0;
        d_adr = '0; d_dat = '0; d_we = 1'b0; d_sel = '0; d_stb = 1'b0; d_cyc = 1'b0;
        s_ack = 1'b0; s_dat = '0;
    endtask

    task automatic do_reset(input int n);
        clear_inputs();
        rst = 1'b1;
        repeat (n) begin
            settle();
            step();
        end
        rst = 1'b0;
    endtask

    initial begin
        int rr_exp [4];
        rr_exp = '{1, 2, 1, 2};
        for (int k = 0; k < 2; k++) begin
            m_own[k] = 0; m_last[k] = 2; m_cnt[k] = 0; m_tmo[k] = 1'b0;
        end
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        step();
        do_reset(2);

        // Reset state and a single instruction read acked on its 2nd bus cycle.
        i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h0000_0100; i_sel = 4'hF;
        settle();
        for (int k = 0; k < 2; k++) begin
            chk("rst_grant", k, 32'(gnt[k]), 32'd0);
            chk("rst_cyc",   k, 32'(mcyc[k]), 32'd0);
        end
        step();
        settle();
        chk("rd_grant", 0, 32'(gnt[0]), 32'd1);
        chk("rd_cyc",   0, 32'(mcyc[0]), 32'd1);
        chk("rd_adr",   0, madr[0], 32'h0000_0100);
        step();
        s_ack = 1'b1; s_dat = 32'h1234_5678;
        settle();
        chk("rd_ack",      0, 32'(ia[0]), 32'd1);
        chk("rd_data",     0, idat[0], 32'h1234_5678);
        chk("rd_other_ack", 0, 32'(da[0]), 32'd0);
        step();
        clear_inputs();
        settle();
        step();

        // Round-robin handoffs with both masters always re-requesting.
        do_reset(1);
        i_cyc = 1'b1; i_stb = 1'b1; d_cyc = 1'b1; d_stb = 1'b1;
        i_adr = 32'h0000_1000; d_adr = 32'h0000_2000;
        settle();
        chk("rr_idle", 0, 32'(gnt[0]), 32'd0);
        step();
        for (int r = 0; r < 4; r++) begin
            settle();
            chk("rr_hold", 0, 32'(gnt[0]), 32'(rr_exp[r]));
            step();
            if (rr_exp[r] == 1) begin i_cyc = 1'b0; i_stb = 1'b0; end
            else begin d_cyc = 1'b0; d_stb = 1'b0; end
            settle();
            chk("rr_release", 0, 32'(gnt[0]), 32'(rr_exp[r]));
            step();
            i_cyc = 1'b1; i_stb = 1'b1; d_cyc = 1'b1; d_stb = 1'b1;
        end
        settle();
        chk("rr_wrap", 0, 32'(gnt[0]), 32'd1);
        step();

        // Fixed priority: data wins every contested arbitration from idle.
        do_reset(1);
        for (int r = 0; r < 3; r++) begin
            i_cyc = 1'b1; i_stb = 1'b1; d_cyc = 1'b1; d_stb = 1'b1;
            settle();
            step();
            settle();
            chk("fp_contest", 1, 32'(gnt[1]), 32'd2);
            step();
            i_cyc = 1'b0; i_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
            settle();
            step();
        end
        i_cyc = 1'b1; i_stb = 1'b1; d_cyc = 1'b1; d_stb = 1'b1;
        settle();
        step();
        d_cyc = 1'b0; d_stb = 1'b0;
        settle();
        step();
        settle();
        chk("fp_instr_after_data", 1, 32'(gnt[1]), 32'd1);
        step();

        // Four-beat data write burst stays atomic while instr waits.
        do_reset(1);
        d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_sel = 4'b0011; d_adr = 32'h0000_3000;
        settle();
        step();
        i_cyc = 1'b1; i_stb = 1'b1;
        for (int b = 0; b < 4; b++) begin
            d_adr = 32'h0000_3000 + 32'(4 * b);
            d_dat = $urandom();
            s_ack = 1'b1; s_dat = $urandom();
            settle();
            for (int k = 0; k < 2; k++) begin
                chk("burst_grant",    k, 32'(gnt[k]), 32'd2);
                chk("burst_sel",      k, 32'(msel[k]), 32'h3);
                chk("burst_adr",      k, madr[k], 32'h0000_3000 + 32'(4 * b));
                chk("burst_ack",      k, 32'(da[k]), 32'd1);
                chk("burst_instr_ack", k, 32'(ia[k]), 32'd0);
            end
            step();
        end
        d_cyc = 1'b0; d_stb = 1'b0; s_ack = 1'b0;
        settle();
        step();
        settle();
        for (int k = 0; k < 2; k++) chk("burst_handoff", k, 32'(gnt[k]), 32'd1);
        step();

        // Reset while data owns with an outstanding strobe; late ack is dropped.
        do_reset(1);
        d_cyc = 1'b1; d_stb = 1'b1; d_adr = 32'h0000_4000;
        settle();
        step();
        settle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_ack = 1'b1; s_dat = 32'hCAFE_F00D;
        settle();
        for (int k = 0; k < 2; k++) begin
            chk("abort_grant", k, 32'(gnt[k]), 32'd0);
            chk("abort_cyc",   k, 32'(mcyc[k]), 32'd0);
            chk("abort_stb",   k, 32'(mstb[k]), 32'd0);
            chk("abort_adr",   k, madr[k], 32'd0);
            chk("abort_ack",   k, 32'(da[k]), 32'd0);
        end
        step();
        clear_inputs();

`ifdef WB_SCR1_ARB_TIMEOUT_EN
        // Slave never answers: synthetic ack after TMO stalled cycles.
        do_reset(1);
        i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h0000_5000;
        settle();
        step();
        for (int c = 1; c <= TMO + 1; c++) begin
            settle();
            if (c <= TMO) begin
                chk("wd_wait_ack", 0, 32'(ia[0]), 32'd0);
            end else begin
                chk("wd_ack",  0, 32'(ia[0]), 32'd1);
                chk("wd_data", 0, idat[0], 32'hDEAD_BEEF);
                chk("wd_stb",  0, 32'(mstb[0]), 32'd0);
            end
            step();
        end
        i_cyc = 1'b0; i_stb = 1'b0;
        settle();
        chk("wd_sticky", 0, 32'(tmo[0]), 32'd1);
        step();
        d_cyc = 1'b1; d_stb = 1'b1; s_ack = 1'b1;
        repeat (3) begin
            settle();
            step();
        end
        chk("wd_sticky_later", 0, 32'(tmo[0]), 32'd1);
        do_reset(1);
        settle();
        chk("wd_cleared", 0, 32'(tmo[0]), 32'd0);
        step();
`endif

        // Randomized traffic, including stray acks while idle and rare resets.
        do_reset(1);
        for (int n = 0; n < 3000; n++) begin
            if (i_cyc) i_cyc = ($urandom_range(3) != 0);
            else       i_cyc = ($urandom_range(1) == 1);
            if (d_cyc) d_cyc = ($urandom_range(3) != 0);
            else       d_cyc = ($urandom_range(1) == 1);
            i_stb = i_cyc && ($urandom_range(1) == 1);
            d_stb = d_cyc && ($urandom_range(1) == 1);
            i_adr = $urandom(); i_dat = $urandom(); i_we = ($urandom_range(1) == 1);
            d_adr = $urandom(); d_dat = $urandom(); d_we = ($urandom_range(1) == 1);
            i_sel = 4'($urandom()); d_sel = 4'($urandom());
            s_ack = ($urandom_range(1) == 1); s_dat = $urandom();
            rst   = ($urandom_range(199) == 0);
            settle();
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
